student_ram: RTL and testbench

STUDENT_RAM -- requirements
Module: student_ram

---
 rtl/student_ram_pkg.sv | 6 +
 rtl/student_ram_register.sv | 14 +
 rtl/student_ram.sv | 63 ++++++
 tb/tb_student_ram.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/student_ram_pkg.sv
// student_ram_pkg: FSM state type and default geometry shared by the student_ram slice.
package student_ram_pkg;
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
endpackage

// File: rtl/student_ram_register.sv
// student_register: one load-enabled storage word, no reset (the sweep zeroes it).
module student_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk)
        if (load_i) data_q <= d_i;
    assign q_o = data_q;
endmodule

// File: rtl/student_ram.sv
// student_ram: DEPTH-word register file with a zeroing sweep after reset or clear.
// Define STUDENT_RAM_BYPASS_EN for same-cycle write-through on out.
module student_ram
    import student_ram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int ADDR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  words [DEPTH];
    logic [WIDTH-1:0]  wr_data, rd_data;
    logic              in_rng, last;
    assign in_rng = {1'b0, address} < DEPTH_V;
    assign last   = cnt_q == LAST;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    always_comb begin
        state_d = (state_q == IDLE) ? (clear ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
        cnt_d   = (state_q == CLEAR && !last) ? cnt_q + 1'b1 : '0;
    end
    always_comb busy = state_q == CLEAR;
    // During a sweep every word sees zero data; only the counter's word is enabled.
    assign wr_data = busy ? '0 : in;
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic we;
        assign we = busy ? (cnt_q == ADDR_W'(g)) : (load && !clear && address == ADDR_W'(g));
        student_register #(.WIDTH(WIDTH)) u_word (
            .clk    (clk),
            .load_i (we),
            .d_i    (wr_data),
            .q_o    (words[g])
        );
    end
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (address == ADDR_W'(i)) rd_data = words[i];
    end
`ifdef STUDENT_RAM_BYPASS_EN
    always_comb out = (busy || !in_rng) ? '0 : (load ? in : rd_data);
`else
    always_comb out = (busy || !in_rng) ? '0 : rd_data;
`endif
endmodule

// File: tb/tb_student_ram.sv
// tb_student_ram: table-driven and scripted checks of student_ram at DEPTH 8 and DEPTH 5.
module tb_student_ram;
    logic        clk = 1'b0;
    logic        rst_n, rst5_n, load, clear;
    logic [15:0] din, out8, out5;
    logic [2:0]  addr;
    logic        busy8, busy5;
    int          tests = 0, fails = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic        ld;
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
        logic [15:0] exp_byp;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    student_ram #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in(din), .load(load), .address(addr),
        .clear(clear), .out(out8), .busy(busy8)
    );
    student_ram #(.WIDTH(16), .DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst5_n), .in(din), .load(load), .address(addr),
        .clear(clear), .out(out5), .busy(busy5)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic cl, input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        load = ld; clear = cl; addr = a; din = d;
        #1;
    endtask

    // Counts rising edges while busy stays high, checking out is held at zero.
    task automatic count_busy(input bit sel, input int exp, input string name);
        int n = 0;
        while ((sel ? busy5 : busy8) && n < 40) begin
            check({name, "_out0"}, sel ? out5 : out8, 16'h0000);
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_cycles"}, 16'(n), 16'(exp));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd3, 16'hBEEF, 16'h0000, 16'hBEEF};
        vecs[1]  = '{1'b0, 3'd3, 16'h0000, 16'hBEEF, 16'hBEEF};
        vecs[2]  = '{1'b0, 3'd2, 16'h0000, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 3'd5, 16'h1234, 16'h0000, 16'h0000};
        vecs[4]  = '{1'b0, 3'd5, 16'h1234, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b0, 3'd5, 16'h1234, 16'h0000, 16'h0000};
        vecs[6]  = '{1'b0, 3'd5, 16'h0000, 16'h0000, 16'h0000};
        vecs[7]  = '{1'b1, 3'd7, 16'h1357, 16'h0000, 16'h1357};
        vecs[8]  = '{1'b1, 3'd7, 16'h2468, 16'h1357, 16'h2468};
        vecs[9]  = '{1'b0, 3'd7, 16'h0000, 16'h2468, 16'h2468};
        vecs[10] = '{1'b0, 3'd3, 16'h0000, 16'hBEEF, 16'hBEEF};

        rst_n = 1'b0; rst5_n = 1'b0; load = 1'b0; clear = 1'b0; addr = '0; din = '0;
        #12;
        check("rst_busy", {15'd0, busy8}, 16'h0001);
        check("rst_out", out8, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        count_busy(1'b0, 8, "reset_sweep");
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 3'(i), 16'h0000);
            check($sformatf("post_reset_a%0d", i), out8, 16'h0000);
        end

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].ld, 1'b0, vecs[i].a, vecs[i].d);
`ifdef STUDENT_RAM_BYPASS_EN
            sb_q.push_back(vecs[i].exp_byp);
`else
            sb_q.push_back(vecs[i].exp);
`endif
            check($sformatf("vec%0d", i), out8, sb_q.pop_front());
        end

        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 3'(i), 16'h00A0 + 16'(i));
        drive(1'b0, 1'b0, 3'd4, 16'h0000);
        check("fill_a4", out8, 16'h00A4);
        drive(1'b0, 1'b1, 3'd0, 16'h0000);
        drive(1'b1, 1'b1, 3'd2, 16'hFFFF);
        check("sweep_busy", {15'd0, busy8}, 16'h0001);
        drive(1'b1, 1'b0, 3'd2, 16'hFFFF);
        count_busy(1'b0, 7, "sweep");
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 3'(i), 16'h0000);
            check($sformatf("post_sweep_a%0d", i), out8, 16'h0000);
        end

        drive(1'b1, 1'b0, 3'd1, 16'h7777);
        drive(1'b1, 1'b1, 3'd1, 16'h5555);
`ifdef STUDENT_RAM_BYPASS_EN
        check("collide_pre", out8, 16'h5555);
`else
        check("collide_pre", out8, 16'h7777);
`endif
        drive(1'b0, 1'b0, 3'd1, 16'h0000);
        check("collide_busy", {15'd0, busy8}, 16'h0001);
        count_busy(1'b0, 8, "collide");
        drive(1'b0, 1'b0, 3'd1, 16'h0000);
        check("collide_a1", out8, 16'h0000);

        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        rst5_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("d5_mid_busy", {15'd0, busy5}, 16'h0001);
        rst5_n = 1'b0;
        #1;
        check("d5_rst_busy", {15'd0, busy5}, 16'h0001);
        check("d5_rst_out", out5, 16'h0000);
        @(negedge clk);
        rst5_n = 1'b1;
        #1;
        count_busy(1'b1, 5, "d5_sweep");
        drive(1'b1, 1'b0, 3'd6, 16'h6666);
        check("d5_a6_wr", out5, 16'h0000);
        drive(1'b0, 1'b0, 3'd6, 16'h0000);
        check("d5_a6_rd", out5, 16'h0000);
        drive(1'b1, 1'b0, 3'd4, 16'h4444);
        drive(1'b0, 1'b0, 3'd4, 16'h0000);
        check("d5_a4_rd", out5, 16'h4444);
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        check("d5_a0_rd", out5, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
